// File: rtl/dac_spi_tx_pkg.sv
// Shared constants and types for the dual serial DAC transmitter.
// The frame word places the power-down bits just above the 12-bit sample.
package dac_spi_tx_pkg;

    localparam int BITS    = 12;
    localparam int OUTPUTS = 2;
    localparam int FRAME   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_1K     = 2'b01,
        MODE_100K   = 2'b10,
        MODE_HIZ    = 2'b11
    } mode_t;

    function automatic logic [FRAME-1:0] frame_word(input logic [1:0] mode,
                                                    input logic [BITS-1:0] sample);
        return {2'b00, mode, sample};
    endfunction

endpackage

// File: rtl/dac_shift_lane.sv
// One DAC data lane: a 16-bit parallel-load register shifted out MSB first.
// Zeros shift in behind the data, so the lane reads 0 once a full frame has left.
module dac_shift_lane
    import dac_spi_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [FRAME-1:0] data,
    output logic             msb
);

    logic [FRAME-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= {sr[FRAME-2:0], 1'b0};
        end
    end

    assign msb = sr[FRAME-1];

endmodule

// File: rtl/dac_spi_tx.sv
// Dual-lane serial DAC transmitter: shared SCLK/SYNC, one data line per channel.
// SCLK is divided from clk; data changes only on SCLK rising so it is stable at every fall.
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [OUTPUTS-1:0][BITS-1:0]   in,
    input  logic [1:0]                     mode,
    input  logic                           valid,
    output logic                           ready,
    output logic                           done,
    output logic                           sclk,
    output logic                           sync_n,
    output logic                           d0,
    output logic                           d1
);

    localparam int             DW       = $clog2(DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);

    state_t         state;
    logic [DW-1:0]  div_cnt;
    logic [4:0]     bit_cnt;
    logic           div_wrap;
    logic           load;
    logic           shift_en;
    logic [OUTPUTS-1:0] lane_msb;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign load     = (state == IDLE) && valid;
    // A wrap while sclk is low is a rising toggle: that is when both lanes advance.
    assign shift_en = (state == SHIFT) && div_wrap && !sclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            sclk    <= 1'b1;
            sync_n  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        ready   <= 1'b0;
                        sync_n  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            sclk <= 1'b0;
                        end else begin
                            sclk <= 1'b1;
                            if (bit_cnt == 5'(FRAME - 1)) begin
                                bit_cnt <= '0;
                                sync_n  <= 1'b1;
                                state   <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                GAP: begin
                    // Holds SYNC high long enough before the next frame can start.
                    if (div_wrap) begin
                        div_cnt <= '0;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < OUTPUTS; i++) begin : g_lane
        dac_shift_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .shift (shift_en),
            .data  (frame_word(mode, in[i])),
            .msb   (lane_msb[i])
        );
    end

    assign d0 = lane_msb[0];
    assign d1 = lane_msb[1];

endmodule
